// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with runtime almost-full/almost-empty thresholds,
// occupancy output, synchronous flush and sticky overflow/underflow flags.
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic [ADDR_W:0]       af_thresh,
  input  logic [ADDR_W:0]       ae_thresh,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_W:0]       count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       count_q;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  set_ovf;
  logic                  set_unf;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FULL_CNT);
  assign almost_empty = (count_q <= ae_thresh);
  assign almost_full  = (count_q >= af_thresh);
  assign count        = count_q;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // when it is also being read. Reads never fall through an empty FIFO.
  assign rd_ok   = fifo_rd & ~fifo_empty;
  assign wr_ok   = fifo_wr & (~fifo_full | rd_ok);
  assign set_ovf = ~flush & fifo_wr & ~wr_ok;
  assign set_unf = ~flush & fifo_rd & ~rd_ok;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= set_ovf | (err_overflow & ~err_clr);
      err_underflow <= set_unf | (err_underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_fifo_param;

  logic       clk;
  logic       RESET;
  logic       flush;
  logic [5:0] data_in;
  logic       fifo_wr;
  logic       fifo_rd;
  logic [3:0] af_thresh;
  logic [3:0] ae_thresh;
  logic       err_clr;
  logic [5:0] data_out;
  logic       data_valid;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic [3:0] count;
  logic       err_overflow;
  logic       err_underflow;

  fifo_param #(.DATA_WIDTH(6), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .RESET(RESET), .flush(flush), .data_in(data_in),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .data_out(data_out),
    .data_valid(data_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of stored entries plus the visible registers.
  logic [5:0] m_q[$];
  logic [5:0] m_dout;
  logic       m_valid;
  logic       m_ovf;
  logic       m_unf;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [5:0] din;
    int         cnt;
    logic [5:0] dout;
    logic       vld;
    logic       ovf;
    logic       unf;
    logic       af;
    logic       full;
    logic       emp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step();
    bit rd_ok, wr_ok;
    if (flush) begin
      m_q.delete();
      m_valid = 1'b0;
      if (err_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      rd_ok = fifo_rd && (m_q.size() > 0);
      wr_ok = fifo_wr && ((m_q.size() < 8) || rd_ok);
      if (err_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (fifo_wr && !wr_ok) m_ovf = 1'b1;
      if (fifo_rd && !rd_ok) m_unf = 1'b1;
      if (rd_ok) m_dout = m_q.pop_front();
      m_valid = rd_ok;
      if (wr_ok) m_q.push_back(data_in);
    end
  endtask

  // Apply current inputs across one rising edge, then settle away from it.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_wr = 1'b0; fifo_rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, " count"}, int'(count), sz);
    chk({tag, " empty"}, int'(fifo_empty), int'(sz == 0));
    chk({tag, " full"}, int'(fifo_full), int'(sz == 8));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(sz <= int'(ae_thresh)));
    chk({tag, " almost_full"}, int'(almost_full), int'(sz >= int'(af_thresh)));
    chk({tag, " data_valid"}, int'(data_valid), int'(m_valid));
    chk({tag, " data_out"}, int'(data_out), int'(m_dout));
    chk({tag, " err_overflow"}, int'(err_overflow), int'(m_ovf));
    chk({tag, " err_underflow"}, int'(err_underflow), int'(m_unf));
  endtask

  task automatic add_vec(input logic wr, input logic rd, input logic clr, input logic [5:0] din,
                         input int cnt, input logic [5:0] dout, input logic vld,
                         input logic ovf, input logic unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt; v.dout = dout;
    v.vld = vld; v.ovf = ovf; v.unf = unf;
    v.af = (cnt >= 6); v.full = (cnt == 8); v.emp = (cnt == 0);
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; idle(); data_in = '0; af_thresh = 4'd0; ae_thresh = 4'd1;
    model_reset();
    #12;
    chk("reset count", int'(count), 0);
    chk("reset empty", int'(fifo_empty), 1);
    chk("reset full", int'(fifo_full), 0);
    chk("reset almost_empty", int'(almost_empty), 1);
    chk("reset almost_full thr0", int'(almost_full), 1);
    af_thresh = 4'd6;
    #1;
    chk("reset almost_full thr6", int'(almost_full), 0);
    chk("reset data_valid", int'(data_valid), 0);
    chk("reset data_out", int'(data_out), 0);
    chk("reset flags", int'({err_overflow, err_underflow}), 0);
    @(negedge clk);
    RESET = 1'b0;
    @(posedge clk); #1;

    // Fill, overflow, drain, underflow, empty simultaneity, err_clr.
    for (int i = 1; i <= 8; i++) add_vec(1, 0, 0, 6'(i), i, 6'h00, 0, 0, 0);
    add_vec(1, 0, 0, 6'h3F, 8, 6'h00, 0, 1, 0);
    for (int i = 1; i <= 8; i++) add_vec(0, 1, 0, 6'h00, 8 - i, 6'(i), 1, 1, 0);
    add_vec(0, 1, 0, 6'h00, 0, 6'h08, 0, 1, 1);
    add_vec(1, 1, 0, 6'h15, 1, 6'h08, 0, 1, 1);
    add_vec(0, 0, 1, 6'h00, 1, 6'h08, 0, 0, 0);
    add_vec(0, 1, 0, 6'h00, 0, 6'h15, 1, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      fifo_wr = vq[i].wr; fifo_rd = vq[i].rd; err_clr = vq[i].clr; data_in = vq[i].din;
      step();
      chk($sformatf("vec%0d count", i), int'(count), vq[i].cnt);
      chk($sformatf("vec%0d data_out", i), int'(data_out), int'(vq[i].dout));
      chk($sformatf("vec%0d data_valid", i), int'(data_valid), int'(vq[i].vld));
      chk($sformatf("vec%0d err_overflow", i), int'(err_overflow), int'(vq[i].ovf));
      chk($sformatf("vec%0d err_underflow", i), int'(err_underflow), int'(vq[i].unf));
      chk($sformatf("vec%0d almost_full", i), int'(almost_full), int'(vq[i].af));
      chk($sformatf("vec%0d full", i), int'(fifo_full), int'(vq[i].full));
      chk($sformatf("vec%0d empty", i), int'(fifo_empty), int'(vq[i].emp));
    end
    idle();

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) begin
      fifo_wr = 1'b1; data_in = 6'(8'h10 + i); step();
    end
    fifo_wr = 1'b1; fifo_rd = 1'b1; data_in = 6'h2A; step();
    chk("fullsim count", int'(count), 8);
    chk("fullsim overflow", int'(err_overflow), 0);
    chk("fullsim data_out", int'(data_out), 8'h10);
    check_model("fullsim");
    fifo_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_model("fullsim drain");
    end
    chk("fullsim last read", int'(data_out), 8'h2A);
    idle();

    // Wrap-around with alternating write/read pairs.
    for (int i = 0; i < 20; i++) begin
      fifo_wr = 1'b1; fifo_rd = 1'b0; data_in = 6'(i + 32); step();
      chk("wrap count1", int'(count), 1);
      fifo_wr = 1'b0; fifo_rd = 1'b1; step();
      chk("wrap count0", int'(count), 0);
      chk("wrap data", int'(data_out), i + 32);
      chk("wrap valid", int'(data_valid), 1);
    end
    idle();

    // Flush with 5 entries and a pending underflow flag.
    fifo_rd = 1'b1; step(); idle();
    for (int i = 0; i < 5; i++) begin
      fifo_wr = 1'b1; data_in = 6'(i + 1); step();
    end
    flush = 1'b1; fifo_wr = 1'b1; data_in = 6'h33; step();
    chk("flush count", int'(count), 0);
    chk("flush empty", int'(fifo_empty), 1);
    chk("flush underflow kept", int'(err_underflow), 1);
    chk("flush overflow", int'(err_overflow), 0);
    idle();

    // Refill, then asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      fifo_wr = 1'b1; data_in = 6'(i + 9); step();
    end
    idle();
    check_model("refill");
    #2 RESET = 1'b1;
    model_reset();
    #1;
    chk("async reset count", int'(count), 0);
    chk("async reset empty", int'(fifo_empty), 1);
    chk("async reset underflow", int'(err_underflow), 0);
    #2 RESET = 1'b0;
    fifo_wr = 1'b1; data_in = 6'h07; step();
    fifo_wr = 1'b0; fifo_rd = 1'b1; step();
    chk("post reset data", int'(data_out), 7);
    chk("post reset valid", int'(data_valid), 1);
    idle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        af_thresh = 4'($urandom_range(0, 8));
        ae_thresh = 4'($urandom_range(0, 8));
      end
      fifo_wr = ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 65 : 35));
      fifo_rd = ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 35 : 65));
      flush   = ($urandom_range(0, 63) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      data_in = 6'($urandom);
      step();
      check_model("random");
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
